// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receive controller.
package uart_rx_pkg;

    // Default frame geometry.
    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned DATA_BITS_DEF  = 8;

    // Receive sequencer states; PARITY is only reachable with UART_RX_PARITY_EN.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Tick counter width: clog2(OVERSAMPLE), never below one bit.
    function automatic int unsigned cnt_w(input int unsigned os);
        return (os > 1) ? $clog2(os) : 1;
    endfunction

    // Bit index width: clog2(DATA_BITS + 1) so the index can reach DATA_BITS.
    function automatic int unsigned bidx_w(input int unsigned db);
        return $clog2(db + 1);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receive holding register hand-off: producer drives data/valid, consumer drives ready.
interface uart_rx_ctrl_if
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS = DATA_BITS_DEF
);

    logic [DATA_BITS-1:0] rhr_data;
    logic                 rhr_valid;
    logic                 rhr_ready;

    modport master (
        output rhr_data,
        output rhr_valid,
        input  rhr_ready
    );

    modport slave (
        input  rhr_data,
        input  rhr_valid,
        output rhr_ready
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Double-register the line; both stages come out of reset at line-idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Oversampling UART receive controller: start detect, mid-bit sampling, framing,
// and a single-entry holding register with valid/ready hand-off.
// Optional parity checking is compiled in with the macro UART_RX_PARITY_EN.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          PARITY_ODD = 1'b0
`endif
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           baud_tick,
    input  logic           rx_data,
    input  logic           err_clr,
    uart_rx_ctrl_if.master rhr,
    output logic           frame_err,
    output logic           overrun,
    output logic           parity_err,
    output logic           busy
);

    localparam int unsigned CNT_W  = cnt_w(OVERSAMPLE);
    localparam int unsigned BIDX_W = bidx_w(DATA_BITS);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0]  CNT_MID   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_BITS - 1);

    rx_state_e            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIDX_W-1:0]    bidx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [DATA_BITS-1:0] rhr_data_q;
    logic                 rhr_valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 busy_q;
    logic                 rxs;
    logic                 consume_c;
    logic                 byte_ok_c;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q;
    logic                 parity_err_q;
`endif

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx_data),
        .q_o   (rxs)
    );

    // Consumer takes the held byte this cycle.
    assign consume_c = rhr_valid_q & rhr.rhr_ready;

    // LSB-first shift: each new sample enters at the MSB end.
    assign shift_d = {rxs, shift_q[DATA_BITS-1:1]};

    // A completed frame is kept only with a good stop bit (and good parity when enabled).
`ifdef UART_RX_PARITY_EN
    assign byte_ok_c = rxs & ~par_bad_q;
`else
    assign byte_ok_c = rxs;
`endif

    // Receive sequencer, counters, shift register, holding register and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bidx_q       <= '0;
            shift_q      <= '0;
            rhr_data_q   <= '0;
            rhr_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            if (consume_c) begin
                rhr_valid_q <= 1'b0;
            end
            // Clearing comes first so an error raised on the same edge survives.
            if (err_clr) begin
                frame_err_q  <= 1'b0;
                overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= 1'b0;
`endif
            end
            if (baud_tick) begin
                case (state_q)
                    IDLE: begin
                        if (!rxs) begin
                            state_q <= START;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    START: begin
                        if (cnt_q == CNT_MID) begin
                            if (rxs) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= DATA;
                                cnt_q   <= '0;
                                bidx_q  <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (cnt_q == CNT_LAST) begin
                            shift_q <= shift_d;
                            cnt_q   <= '0;
                            bidx_q  <= bidx_q + BIDX_W'(1);
                            if (bidx_q == BIDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= PARITY;
`else
                                state_q <= STOP;
`endif
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (cnt_q == CNT_LAST) begin
                            // Data bits plus parity bit must have the configured overall parity.
                            par_bad_q <= ((^shift_q) ^ rxs) != PARITY_ODD;
                            cnt_q     <= '0;
                            state_q   <= STOP;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
`endif
                    STOP: begin
                        if (cnt_q == CNT_LAST) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                            if (!rxs) begin
                                frame_err_q <= 1'b1;
                            end
`ifdef UART_RX_PARITY_EN
                            if (par_bad_q) begin
                                parity_err_q <= 1'b1;
                            end
`endif
                            if (byte_ok_c) begin
                                if (!rhr_valid_q || consume_c) begin
                                    rhr_data_q  <= shift_q;
                                    rhr_valid_q <= 1'b1;
                                end else begin
                                    overrun_q <= 1'b1;
                                end
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rhr.rhr_data  = rhr_data_q;
    assign rhr.rhr_valid = rhr_valid_q;
    assign frame_err     = frame_err_q;
    assign overrun       = overrun_q;
    assign busy          = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err    = parity_err_q;
`else
    assign parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frame table plus glitch, overrun, mid-frame reset
// and (with UART_RX_PARITY_EN) parity sequences.
module tb_uart_rx_ctrl;

    localparam int unsigned DB      = 8;
    localparam int unsigned OS      = 16;
    localparam int          BIT_CLK = OS * 4;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         pulses;
        logic       fe;
    } vec_t;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx_data   = 1'b1;
    logic       err_clr   = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic       busy;
    logic [1:0] tick_div  = '0;

    int         valid_total = 0;
    logic [7:0] last_data   = '0;
    int         errors      = 0;
    int         checks      = 0;
    int         v0;
    vec_t       vecs [6];

    uart_rx_ctrl_if #(.DATA_BITS(DB)) rhr_if ();

    uart_rx_ctrl #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (OS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_tick  (baud_tick),
        .rx_data    (rx_data),
        .err_clr    (err_clr),
        .rhr        (rhr_if),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // One baud tick every fourth clock, driven away from the active edge.
    always @(negedge clk) begin
        tick_div  = tick_div + 2'd1;
        baud_tick = (tick_div == 2'd0);
    end

    // Count cycles with a valid byte presented and remember the last one.
    always @(negedge clk) begin
        if (rhr_if.rhr_valid === 1'b1) begin
            valid_total = valid_total + 1;
            last_data   = rhr_if.rhr_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx_data = b;
        wait_clk(BIT_CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < int'(DB); i++) send_bit(d[i]);
        if (PAR_EN) send_bit(par);
        send_bit(stop);
        rx_data = 1'b1;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        wait_clk(1);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 0, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 1, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1, 1'b0};
        vecs[4] = '{8'h81, 1'b1, 1, 1'b0};
        vecs[5] = '{8'h3C, 1'b1, 1, 1'b0};
        rhr_if.rhr_ready = 1'b1;

        // Power-on reset values.
        wait_clk(3);
        check("rst_data",   32'(rhr_if.rhr_data),  32'h0);
        check("rst_valid",  32'(rhr_if.rhr_valid), 32'h0);
        check("rst_fe",     32'(frame_err),        32'h0);
        check("rst_ovr",    32'(overrun),          32'h0);
        check("rst_par",    32'(parity_err),       32'h0);
        check("rst_busy",   32'(busy),             32'h0);
        reset = 1'b0;
        wait_clk(4);

        // Table of whole frames with the consumer always ready.
        for (int i = 0; i < 6; i++) begin
            pulse_clr();
            check($sformatf("v%0d_clr_fe", i), 32'(frame_err), 32'h0);
            v0 = valid_total;
            send_frame(vecs[i].data, vecs[i].stop, ^vecs[i].data);
            wait_clk(40);
            check($sformatf("v%0d_pulses", i), 32'(valid_total - v0), 32'(vecs[i].pulses));
            if (vecs[i].pulses != 0)
                check($sformatf("v%0d_data", i), 32'(last_data), 32'(vecs[i].data));
            check($sformatf("v%0d_fe", i),    32'(frame_err),        32'(vecs[i].fe));
            check($sformatf("v%0d_ovr", i),   32'(overrun),          32'h0);
            check($sformatf("v%0d_par", i),   32'(parity_err),       32'h0);
            check($sformatf("v%0d_busy", i),  32'(busy),             32'h0);
            check($sformatf("v%0d_valid", i), 32'(rhr_if.rhr_valid), 32'h0);
        end

        // Short low glitch: start rejected at mid start bit, nothing flagged.
        pulse_clr();
        v0 = valid_total;
        rx_data = 1'b0;
        wait_clk(16);
        check("glitch_busy_hi", 32'(busy), 32'h1);
        rx_data = 1'b1;
        wait_clk(80);
        check("glitch_busy_lo", 32'(busy),                 32'h0);
        check("glitch_pulses",  32'(valid_total - v0),     32'h0);
        check("glitch_fe",      32'(frame_err),            32'h0);
        check("glitch_ovr",     32'(overrun),              32'h0);

        // Consumer stalled: second byte overruns, first byte held.
        rhr_if.rhr_ready = 1'b0;
        send_frame(8'h11, 1'b1, ^8'h11);
        wait_clk(40);
        check("ovr_first_valid", 32'(rhr_if.rhr_valid), 32'h1);
        check("ovr_first_data",  32'(rhr_if.rhr_data),  32'h11);
        check("ovr_first_flag",  32'(overrun),          32'h0);
        send_frame(8'h22, 1'b1, ^8'h22);
        wait_clk(40);
        check("ovr_flag",  32'(overrun),          32'h1);
        check("ovr_data",  32'(rhr_if.rhr_data),  32'h11);
        check("ovr_valid", 32'(rhr_if.rhr_valid), 32'h1);
        check("ovr_fe",    32'(frame_err),        32'h0);
        rhr_if.rhr_ready = 1'b1;
        wait_clk(1);
        check("ovr_drain_valid", 32'(rhr_if.rhr_valid), 32'h0);
        check("ovr_drain_data",  32'(rhr_if.rhr_data),  32'h11);

        // Reset in the middle of the data bits of 0xFF; reset acts without a clock edge.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        wait_clk(20);
        check("mid_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        check("mid_rst_data",  32'(rhr_if.rhr_data),  32'h0);
        check("mid_rst_valid", 32'(rhr_if.rhr_valid), 32'h0);
        check("mid_rst_ovr",   32'(overrun),          32'h0);
        check("mid_rst_fe",    32'(frame_err),        32'h0);
        check("mid_rst_busy",  32'(busy),             32'h0);
        rx_data = 1'b1;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(8);
        v0 = valid_total;
        send_frame(8'h5A, 1'b1, ^8'h5A);
        wait_clk(40);
        check("post_rst_pulses", 32'(valid_total - v0), 32'h1);
        check("post_rst_data",   32'(last_data),        32'h5A);
        check("post_rst_fe",     32'(frame_err),        32'h0);
        check("post_rst_ovr",    32'(overrun),          32'h0);
        check("post_rst_busy",   32'(busy),             32'h0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so a parity bit of 0 is wrong.
        v0 = valid_total;
        send_frame(8'h07, 1'b1, 1'b0);
        wait_clk(40);
        check("par_bad_flag",   32'(parity_err),        32'h1);
        check("par_bad_pulses", 32'(valid_total - v0),  32'h0);
        check("par_bad_fe",     32'(frame_err),         32'h0);
        pulse_clr();
        check("par_clr", 32'(parity_err), 32'h0);
        v0 = valid_total;
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clk(40);
        check("par_ok_flag",   32'(parity_err),       32'h0);
        check("par_ok_pulses", 32'(valid_total - v0), 32'h1);
        check("par_ok_data",   32'(last_data),        32'h07);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
